// File: rtl/sram64x128_arbiter.sv
// Two-requester round-robin front end that owns every pin of one SRAM1RW64x128 macro.
// Optional post-reset clear of all words: define SRAM64X128_ARB_INIT_CLEAR_EN.
module sram64x128_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 128
) (
  input  logic              CE,
  input  logic              RST,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_WE,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  output logic              RSP0_VALID,
  output logic [DATA_W-1:0] RSP0_RDATA,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_WE,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP1_RDATA,
  output logic              INIT_DONE,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic              SRAM_CSB,
  output logic              SRAM_WEB,
  output logic              SRAM_OEB,
  output logic [DATA_W-1:0] SRAM_I,
  input  logic [DATA_W-1:0] SRAM_O
);

  logic              run;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;

`ifdef SRAM64X128_ARB_INIT_CLEAR_EN
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;
  localparam logic [ADDR_W-1:0] AddrMax = '1;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] cnt_q;

  // The edge that puts the last address on the pins also leaves INIT; the counter then freezes.
  always_ff @(posedge CE) begin
    if (RST) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else if (state_q == StInit) begin
      if (cnt_q == AddrMax) begin
        state_q <= StRun;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign run       = (state_q == StRun);
  assign init_wr   = (state_q == StInit);
  assign init_addr = cnt_q;
`else
  logic run_q;

  always_ff @(posedge CE) begin
    if (RST) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign run       = run_q;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign INIT_DONE = run;

  logic              rr_q;
  logic              grant_any;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Reset gates READY so a requester never sees an accept that the reset edge discards.
  always_comb begin
    grant_any  = run && !RST && (REQ0_VALID || REQ1_VALID);
    grant_id   = (REQ0_VALID && REQ1_VALID) ? rr_q : REQ1_VALID;
    REQ0_READY = grant_any && !grant_id;
    REQ1_READY = grant_any && grant_id;
    sel_we     = grant_id ? REQ1_WE    : REQ0_WE;
    sel_addr   = grant_id ? REQ1_ADDR  : REQ0_ADDR;
    sel_wdata  = grant_id ? REQ1_WDATA : REQ0_WDATA;
  end

  always_ff @(posedge CE) begin
    if (RST) begin
      rr_q <= 1'b0;
    end else if (grant_any) begin
      rr_q <= ~grant_id;
    end
  end

  always_ff @(posedge CE) begin
    if (RST) begin
      SRAM_CSB <= 1'b1;
      SRAM_WEB <= 1'b1;
      SRAM_A   <= '0;
      SRAM_I   <= '0;
    end else if (init_wr) begin
      SRAM_CSB <= 1'b0;
      SRAM_WEB <= 1'b0;
      SRAM_A   <= init_addr;
      SRAM_I   <= '0;
    end else if (grant_any) begin
      SRAM_CSB <= 1'b0;
      SRAM_WEB <= ~sel_we;
      SRAM_A   <= sel_addr;
      SRAM_I   <= sel_wdata;
    end else begin
      SRAM_CSB <= 1'b1;
      SRAM_WEB <= 1'b1;
    end
  end

  // Owner tag follows the command on the pins, then the macro read cycle, then the response.
  logic issue_id_q;
  logic oe_q;
  logic oe_id_q;

  always_ff @(posedge CE) begin
    if (RST) begin
      issue_id_q <= 1'b0;
      oe_q       <= 1'b0;
      oe_id_q    <= 1'b0;
    end else begin
      issue_id_q <= grant_id;
      oe_q       <= !SRAM_CSB && SRAM_WEB;
      oe_id_q    <= issue_id_q;
    end
  end

  assign SRAM_OEB = !oe_q;

  always_ff @(posedge CE) begin
    if (RST) begin
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      RSP0_RDATA <= '0;
      RSP1_RDATA <= '0;
    end else begin
      RSP0_VALID <= oe_q && !oe_id_q;
      RSP1_VALID <= oe_q && oe_id_q;
      if (oe_q && !oe_id_q) begin
        RSP0_RDATA <= SRAM_O;
      end
      if (oe_q && oe_id_q) begin
        RSP1_RDATA <= SRAM_O;
      end
    end
  end

endmodule
